icache_ctrl_nway: RTL and testbench

//  Control FSM for a parametrised N-way set-associative, read-only instruction cache.

---
 rtl/icache_ctrl_nway.sv | 169 ++++++++++++++++
 tb/tb_icache_ctrl_nway.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl_nway.sv
// icache_ctrl_nway: control FSM for an N-way set-associative read-only icache.
// Handles hit/miss sequencing, line fill, tree pseudo-LRU victim choice with
// invalid-first priority, and whole-cache flush.
// Optional build macro: ICACHE_PERF_CNT_EN enables saturating hit/fill counters;
// without it req_count/miss_count are tied to zero.
module icache_ctrl_nway #(
    parameter int unsigned WAYS   = 4,
    parameter int unsigned WAYS_W = $clog2(WAYS),
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    output logic              mem_resp,
    input  logic              flush,
    input  logic [WAYS-1:0]   hit_way,
    input  logic [WAYS-1:0]   valid_out,
    output logic              pmem_read,
    input  logic              pmem_resp,
    output logic [WAYS-1:0]   write_enable,
    output logic [WAYS-1:0]   load_tag,
    output logic [WAYS-1:0]   load_valid,
    output logic [WAYS-1:0]   set_valid,
    output logic [WAYS_W-1:0] victim_way,
    output logic [CNT_W-1:0]  req_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned NODES = WAYS - 1;

    localparam logic [1:0] S_LOOKUP = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [NODES-1:0]  plru, plru_nxt;
    logic [WAYS_W-1:0] victim_nxt;
    logic              flush_pend, flush_pend_nxt;
    logic [WAYS-1:0]   victim_oh;

    // Lowest-index set bit of a vector (0 when empty).
    function automatic logic [WAYS_W-1:0] lowest_set(input logic [WAYS-1:0] v);
        logic [WAYS_W-1:0] idx;
        idx = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (v[i]) idx = WAYS_W'(i);
        end
        return idx;
    endfunction

    // Point every node on the path to 'way' away from it (heap order, root = node 0).
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WAYS_W-1:0] way);
        logic [WAYS-1:0]   tree;
        logic [WAYS_W-1:0] node;
        logic [WAYS_W-1:0] path;
        tree = {1'b0, bits};
        node = '0;
        path = way;
        for (int l = 0; l < int'(WAYS_W); l++) begin
            tree[node] = ~path[WAYS_W-1];
            node       = (node << 1) + WAYS_W'(1) + WAYS_W'(path[WAYS_W-1]);
            path       = path << 1;
        end
        return tree[NODES-1:0];
    endfunction

    // Walk the tree from the root following the node bits to the victim leaf.
    function automatic logic [WAYS_W-1:0] plru_victim(input logic [NODES-1:0] bits);
        logic [WAYS-1:0]   tree;
        logic [WAYS_W-1:0] node;
        logic [WAYS_W-1:0] way;
        logic              dir;
        tree = {1'b0, bits};
        node = '0;
        way  = '0;
        for (int l = 0; l < int'(WAYS_W); l++) begin
            dir  = tree[node];
            way  = (way << 1) | WAYS_W'(dir);
            node = (node << 1) + WAYS_W'(1) + WAYS_W'(dir);
        end
        return way;
    endfunction

    assign victim_oh = WAYS'(1) << victim_way;

    // Next-state, PLRU update and array control outputs.
    always_comb begin
        state_nxt      = state;
        plru_nxt       = plru;
        victim_nxt     = victim_way;
        flush_pend_nxt = flush_pend;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        write_enable   = '0;
        load_tag       = '0;
        load_valid     = '0;
        set_valid      = '0;
        case (state)
            S_LOOKUP: begin
                if (flush) begin
                    state_nxt = S_FLUSH;
                end else if (mem_read) begin
                    if (|hit_way) begin
                        // Gated by rst_n so the response stays low while in reset.
                        mem_resp = rst_n;
                        plru_nxt = plru_touch(plru, lowest_set(hit_way));
                    end else begin
                        state_nxt  = S_FILL;
                        victim_nxt = (&valid_out) ? plru_victim(plru)
                                                  : lowest_set(~valid_out);
                    end
                end
            end
            S_FILL: begin
                pmem_read    = 1'b1;
                write_enable = victim_oh;
                if (flush) flush_pend_nxt = 1'b1;
                if (pmem_resp) begin
                    load_tag   = victim_oh;
                    load_valid = victim_oh;
                    set_valid  = victim_oh;
                    plru_nxt   = plru_touch(plru, victim_way);
                    state_nxt  = (flush_pend || flush) ? S_FLUSH : S_LOOKUP;
                end
            end
            S_FLUSH: begin
                load_valid     = '1;
                plru_nxt       = '0;
                flush_pend_nxt = 1'b0;
                state_nxt      = S_LOOKUP;
            end
            default: state_nxt = S_LOOKUP;
        endcase
    end

    // State, PLRU tree, victim and pending-flush registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LOOKUP;
            plru       <= '0;
            victim_way <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            plru       <= plru_nxt;
            victim_way <= victim_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating hit and completed-fill counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_count  <= '0;
            miss_count <= '0;
        end else begin
            if (mem_resp && (req_count != '1)) req_count <= req_count + CNT_W'(1);
            if ((state == S_FILL) && pmem_resp && (miss_count != '1))
                miss_count <= miss_count + CNT_W'(1);
        end
    end
`else
    assign req_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Self-checking bench for icache_ctrl_nway (WAYS=4) with a tag/valid datapath
// stand-in and a reference model of the cache contents and tree PLRU.
module tb_icache_ctrl_nway;

    localparam int WAYS = 4;
    localparam int WW   = 2;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read;
    logic          mem_resp;
    logic          flush;
    logic [WAYS-1:0] hit_way;
    logic [WAYS-1:0] valid_out;
    logic          pmem_read;
    logic          pmem_resp;
    logic [WAYS-1:0] write_enable, load_tag, load_valid, set_valid;
    logic [WW-1:0] victim_way;
    logic [CW-1:0] req_count, miss_count;

    logic [7:0]      cur_tag;
    logic [7:0]      dp_tag [WAYS];
    logic [WAYS-1:0] dp_valid;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state
    bit       ref_valid [WAYS];
    bit [7:0] ref_tag   [WAYS];
    bit       ref_tree  [WAYS];   // heap nodes 1..WAYS-1
    int       ref_reqs;
    int       ref_misses;

    icache_ctrl_nway #(.WAYS(WAYS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_resp(mem_resp),
        .flush(flush), .hit_way(hit_way), .valid_out(valid_out),
        .pmem_read(pmem_read), .pmem_resp(pmem_resp),
        .write_enable(write_enable), .load_tag(load_tag), .load_valid(load_valid),
        .set_valid(set_valid), .victim_way(victim_way),
        .req_count(req_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: tag/valid arrays driven by the controller's loads.
    always_comb begin
        for (int i = 0; i < WAYS; i++) hit_way[i] = dp_valid[i] && (dp_tag[i] == cur_tag);
    end
    assign valid_out = dp_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp_valid <= '0;
        else begin
            for (int i = 0; i < WAYS; i++) begin
                if (load_tag[i])   dp_tag[i]   <= cur_tag;
                if (load_valid[i]) dp_valid[i] <= set_valid[i];
            end
        end
    end

    function automatic int ref_lookup(input bit [7:0] tag);
        for (int i = 0; i < WAYS; i++) if (ref_valid[i] && ref_tag[i] == tag) return i;
        return -1;
    endfunction

    function automatic void ref_touch(input int w);
        int n;
        n = w + WAYS;
        while (n > 1) begin
            ref_tree[n / 2] = (n % 2 == 0);
            n = n / 2;
        end
    endfunction

    function automatic int ref_pick_victim();
        int n;
        for (int i = 0; i < WAYS; i++) if (!ref_valid[i]) return i;
        n = 1;
        while (n < WAYS) n = 2 * n + int'(ref_tree[n]);
        return n - WAYS;
    endfunction

    function automatic void ref_flush();
        for (int i = 0; i < WAYS; i++) begin
            ref_valid[i] = 1'b0;
            ref_tree[i]  = 1'b0;
        end
    endfunction

    function automatic void ref_reset();
        ref_flush();
        ref_reqs   = 0;
        ref_misses = 0;
    endfunction

    function automatic int exp_cnt(input int v);
`ifdef ICACHE_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_read = 1'b0; flush = 1'b0; pmem_resp = 1'b0; cur_tag = 8'h00;
        ref_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One fetch: starts just after a negedge, holds mem_read until mem_resp.
    task automatic run_request(input logic [7:0] tag, input int lat, input int flush_at);
        int hit, v, guard, fa;
        bit done;
        logic [WAYS-1:0] oh;
        done = 1'b0; guard = 0; fa = flush_at;
        mem_read = 1'b1; cur_tag = tag;
        while (!done && guard < 4) begin
            guard++;
            #1;
            hit = ref_lookup(tag);
            n_run++;
            if (hit >= 0) begin
                if (mem_resp !== 1'b1 || pmem_read !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hit tag=%0h: mem_resp=%b pmem_read=%b, want 1/0", tag, mem_resp, pmem_read);
                end
                ref_touch(hit);
                ref_reqs++;
                done = 1'b1;
            end else begin
                if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
                    n_fail++;
                    $display("FAIL miss_lookup tag=%0h: mem_resp=%b pmem_read=%b, want 0/0", tag, mem_resp, pmem_read);
                end
                v  = ref_pick_victim();
                oh = WAYS'(1) << v;
                for (int c = 1; c <= lat; c++) begin
                    @(negedge clk);
                    pmem_resp = (c == lat);
                    flush     = (c == fa);
                    #1;
                    n_run++;
                    if (pmem_read !== 1'b1 || write_enable !== oh || victim_way !== WW'(v) || mem_resp !== 1'b0) begin
                        n_fail++;
                        $display("FAIL fill tag=%0h cyc=%0d: pmem_read=%b we=%b victim=%0d resp=%b, want 1 %b %0d 0",
                                 tag, c, pmem_read, write_enable, victim_way, mem_resp, oh, v);
                    end
                    n_run++;
                    if (c == lat) begin
                        if ({load_tag, load_valid, set_valid} !== {oh, oh, oh}) begin
                            n_fail++;
                            $display("FAIL fill_load tag=%0h: lt=%b lv=%b sv=%b, want %b", tag, load_tag, load_valid, set_valid, oh);
                        end
                    end else if ({load_tag, load_valid, set_valid} !== '0) begin
                        n_fail++;
                        $display("FAIL fill_idle tag=%0h: lt=%b lv=%b sv=%b, want 0", tag, load_tag, load_valid, set_valid);
                    end
                end
                ref_valid[v] = 1'b1;
                ref_tag[v]   = tag;
                ref_touch(v);
                ref_misses++;
                @(negedge clk);
                pmem_resp = 1'b0; flush = 1'b0;
                if (fa > 0) begin
                    #1;
                    n_run++;
                    if (load_valid !== 4'b1111 || set_valid !== 4'b0000 || mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
                        n_fail++;
                        $display("FAIL flush_cycle: lv=%b sv=%b resp=%b pread=%b, want 1111 0000 0 0", load_valid, set_valid, mem_resp, pmem_read);
                    end
                    ref_flush();
                    fa = 0;
                    @(negedge clk);
                end
            end
        end
        if (!done) begin
            n_run++; n_fail++;
            $display("FAIL req_timeout tag=%0h: no mem_resp, want one", tag);
        end
        @(negedge clk);
        mem_read = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b1; flush = 1'b0; pmem_resp = 1'b0; cur_tag = 8'h00;
        ref_reset();
        repeat (2) @(negedge clk);
        n_run++;
        if ({mem_resp, pmem_read, write_enable, load_tag, load_valid, set_valid, victim_way, req_count, miss_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: resp=%b pread=%b we=%b vw=%0d rc=%0d mc=%0d, want all 0",
                     mem_resp, pmem_read, write_enable, victim_way, req_count, miss_count);
        end
        mem_read = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_run++;
            if ({mem_resp, pmem_read, write_enable, load_tag, load_valid, set_valid, victim_way} !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs cyc=%0d: resp=%b pread=%b we=%b lv=%b, want all 0", i, mem_resp, pmem_read, write_enable, load_valid);
            end
        end
    endtask

    task automatic test_cold_miss();
        run_request(8'h10, 3, 0);
    endtask

    task automatic test_plru();
        do_reset();
        for (int i = 0; i < WAYS; i++) run_request(8'h20 + 8'(i), 2, 0);
        for (int i = 0; i < WAYS; i++) run_request(8'h20 + 8'(i), 1, 0);
        run_request(8'h2f, 2, 0);
    endtask

    task automatic test_flush_mid_fill();
        run_request(8'h30, 3, 1);
        run_request(8'h30, 2, 0);
    endtask

    task automatic test_flush_lookup();
        mem_read = 1'b1; cur_tag = 8'h30; flush = 1'b1;
        #1;
        n_run++;
        if (mem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_lookup_resp: mem_resp=%b, want 0", mem_resp);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_run++;
        if (load_valid !== 4'b1111 || set_valid !== 4'b0000 || mem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_lookup_cycle: lv=%b sv=%b resp=%b, want 1111 0000 0", load_valid, set_valid, mem_resp);
        end
        ref_flush();
        @(negedge clk);
        run_request(8'h30, 2, 0);
    endtask

    task automatic test_reset_mid_fill();
        mem_read = 1'b1; cur_tag = 8'h55;
        @(negedge clk);
        #1;
        n_run++;
        if (pmem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_fill: pmem_read=%b, want 1", pmem_read);
        end
        #1 rst_n = 1'b0;
        #1;
        n_run++;
        if (pmem_read !== 1'b0 || write_enable !== '0 || victim_way !== '0 || mem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: pread=%b we=%b vw=%0d resp=%b, want 0", pmem_read, write_enable, victim_way, mem_resp);
        end
        ref_reset();
        @(negedge clk);
        mem_read = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_run++;
        if ({mem_resp, pmem_read, write_enable, load_valid} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: resp=%b pread=%b we=%b lv=%b, want 0", mem_resp, pmem_read, write_enable, load_valid);
        end
        run_request(8'h55, 2, 0);
    endtask

    task automatic test_counters();
        logic [7:0] t;
        do_reset();
        for (int i = 0; i < 3; i++) run_request(8'h40 + 8'(i), 2, 0);
        for (int i = 0; i < 7; i++) begin
            t = 8'h40 + 8'($urandom_range(0, 2));
            run_request(t, 1, 0);
        end
        n_run++;
        if (req_count !== CW'(exp_cnt(10)) || miss_count !== CW'(exp_cnt(3))) begin
            n_fail++;
            $display("FAIL counters: req=%0d miss=%0d, want %0d %0d", req_count, miss_count, exp_cnt(10), exp_cnt(3));
        end
    endtask

    task automatic test_random();
        logic [7:0] t;
        int lat, fa;
        for (int i = 0; i < 80; i++) begin
            t   = 8'h60 + 8'($urandom_range(0, 6));
            lat = int'($urandom_range(1, 4));
            fa  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, lat)) : 0;
            run_request(t, lat, fa);
        end
        n_run++;
        if (req_count !== CW'(exp_cnt(ref_reqs)) || miss_count !== CW'(exp_cnt(ref_misses))) begin
            n_fail++;
            $display("FAIL random_counters: req=%0d miss=%0d, want %0d %0d",
                     req_count, miss_count, exp_cnt(ref_reqs), exp_cnt(ref_misses));
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; flush = 1'b0; pmem_resp = 1'b0; cur_tag = 8'h00;
        for (int i = 0; i < WAYS; i++) dp_tag[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_plru();
        test_flush_mid_fill();
        test_flush_lookup();
        test_reset_mid_fill();
        test_counters();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
